// File: rtl/zoom_command_dispatcher_if.sv
`default_nettype none
// ============================================================================
// Module   : zoom_command_dispatcher_if
// Purpose  : Instruction push handshake and memory-controller command bus.
// Revision : 1.0
// ============================================================================

interface zoom_command_dispatcher_if;
    logic [31:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        mc_enable;
    logic [2:0]  mc_operation;
    logic [16:0] mc_addr_base;
    logic [7:0]  mc_color;
    logic [2:0]  current_zoom;
    logic        mc_done;
    logic [7:0]  mem_rd_data;

    // master: the dispatcher; slave: PIO bridge plus memory controller
    modport master (
        input  instr_in, instr_valid, mc_done, mem_rd_data,
        output instr_ready, mc_enable, mc_operation, mc_addr_base, mc_color, current_zoom
    );
    modport slave (
        output instr_in, instr_valid, mc_done, mem_rd_data,
        input  instr_ready, mc_enable, mc_operation, mc_addr_base, mc_color, current_zoom
    );
endinterface

`default_nettype wire

// File: rtl/zoom_command_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : zoom_command_dispatcher
// Purpose  : Instruction FIFO, decode/validate, zoom tracking and MC handshake.
// Revision : 1.0
// ============================================================================

module zoom_command_dispatcher #(
    parameter int         FIFO_DEPTH  = 4,
    parameter int         ACK_TIMEOUT = 4,
    parameter logic [2:0] ZOOM_RESET  = 3'b010
) (
    input  wire logic                 clock,
    input  wire logic                 reset_n,
    zoom_command_dispatcher_if.master bus,
    input  wire logic                 clear_flags,
    output logic [7:0]                rd_data,
    output logic                      busy,
    output logic                      cmd_done,
    output logic                      err_invalid,
    output logic                      err_zoom,
    output logic                      err_timeout
);
    localparam int                 c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W     = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_PTR_W:0]   c_FULL      = FIFO_DEPTH[c_PTR_W:0];
    localparam logic [c_PTR_W:0]   c_COUNT_ONE = 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = 1;
    localparam logic [c_CNT_W-1:0] c_ACK_ONE   = 1;
    localparam logic [c_CNT_W-1:0] c_ACK_LAST  = c_CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] c_OP_ZOOM_RST = 3'b000;
    localparam logic [2:0] c_OP_RD_DATA  = 3'b001;
    localparam logic [2:0] c_OP_NHI      = 3'b011;
    localparam logic [2:0] c_OP_PR       = 3'b100;
    localparam logic [2:0] c_OP_NH       = 3'b101;
    localparam logic [2:0] c_OP_BA       = 3'b110;
    localparam logic [2:0] c_OP_INVALID  = 3'b111;
    localparam logic [2:0] c_ZOOM_MAX    = 3'b100;
    localparam logic [2:0] c_ZOOM_MIN    = 3'b000;
    localparam logic [2:0] c_ZOOM_STEP   = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    logic [27:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    state_t             r_state;
    logic [27:0]        r_cmd;
    logic [c_CNT_W-1:0] r_ack_cnt;
    logic [2:0]         r_zoom;
    logic               r_mc_enable;
    logic [2:0]         r_mc_op;
    logic [16:0]        r_mc_addr;
    logic [7:0]         r_mc_color;
    logic [7:0]         r_rd_data;
    logic               r_cmd_done;
    logic               r_err_invalid;
    logic               r_err_zoom;
    logic               r_err_timeout;

    logic               w_push;
    logic               w_pop;
    logic [2:0]         w_op;
    logic               w_zoom_in;
    logic               w_zoom_out;
    logic               w_unused;

    // Ready looks only at the registered count: a same-edge pop never frees a full slot.
    assign bus.instr_ready = (r_count != c_FULL);
    assign w_push          = bus.instr_valid && bus.instr_ready;
    assign w_pop           = (r_state == S_IDLE) && (r_count != '0);
    assign w_op            = r_cmd[2:0];
    assign w_zoom_in       = (w_op == c_OP_NHI) || (w_op == c_OP_PR);
    assign w_zoom_out      = (w_op == c_OP_NH)  || (w_op == c_OP_BA);
    assign w_unused        = &{1'b0, bus.instr_in[31:28]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_COUNT_ONE;
                2'b01:   r_count <= r_count - c_COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= bus.instr_in[27:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_cmd         <= '0;
            r_ack_cnt     <= '0;
            r_zoom        <= ZOOM_RESET;
            r_mc_enable   <= 1'b0;
            r_mc_op       <= '0;
            r_mc_addr     <= '0;
            r_mc_color    <= '0;
            r_rd_data     <= '0;
            r_cmd_done    <= 1'b0;
            r_err_invalid <= 1'b0;
            r_err_zoom    <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_mc_enable <= 1'b0;
            r_cmd_done  <= 1'b0;
            // Clearing comes first so a set on the same edge wins.
            if (clear_flags) begin
                r_err_invalid <= 1'b0;
                r_err_zoom    <= 1'b0;
                r_err_timeout <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_cmd   <= r_mem[r_rd_ptr];
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_op == c_OP_INVALID) begin
                        r_err_invalid <= 1'b1;
                        r_cmd_done    <= 1'b1;
                        r_state       <= S_FINISH;
                    end else if (w_op == c_OP_ZOOM_RST) begin
                        r_zoom     <= ZOOM_RESET;
                        r_cmd_done <= 1'b1;
                        r_state    <= S_FINISH;
                    end else if ((w_zoom_in && r_zoom == c_ZOOM_MAX) ||
                                 (w_zoom_out && r_zoom == c_ZOOM_MIN)) begin
                        r_err_zoom <= 1'b1;
                        r_cmd_done <= 1'b1;
                        r_state    <= S_FINISH;
                    end else begin
                        r_mc_op     <= w_op;
                        r_mc_addr   <= r_cmd[19:3];
                        r_mc_color  <= r_cmd[27:20];
                        r_mc_enable <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ack_cnt <= '0;
                    r_state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (!bus.mc_done) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_ack_cnt == c_ACK_LAST) begin
                        r_err_timeout <= 1'b1;
                        r_cmd_done    <= 1'b1;
                        r_state       <= S_FINISH;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + c_ACK_ONE;
                    end
                end
                S_WAIT_DONE: begin
                    // Long algorithm runs live here, so there is deliberately no timeout.
                    if (bus.mc_done) begin
                        if (w_op == c_OP_RD_DATA) r_rd_data <= bus.mem_rd_data;
                        if (w_zoom_in)  r_zoom <= r_zoom + c_ZOOM_STEP;
                        if (w_zoom_out) r_zoom <= r_zoom - c_ZOOM_STEP;
                        r_cmd_done <= 1'b1;
                        r_state    <= S_FINISH;
                    end
                end
                S_FINISH: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mc_enable    = r_mc_enable;
    assign bus.mc_operation = r_mc_op;
    assign bus.mc_addr_base = r_mc_addr;
    assign bus.mc_color     = r_mc_color;
    assign bus.current_zoom = r_zoom;
    assign rd_data          = r_rd_data;
    assign busy             = (r_count != '0) || (r_state != S_IDLE);
    assign cmd_done         = r_cmd_done;
    assign err_invalid      = r_err_invalid;
    assign err_zoom         = r_err_zoom;
    assign err_timeout      = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_zoom_command_dispatcher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_zoom_command_dispatcher
// Purpose  : Randomized self-checking bench with a command-level reference model.
// Revision : 1.0
// ============================================================================

module tb_zoom_command_dispatcher;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       clear_flags;
    logic [7:0] rd_data;
    logic       busy, cmd_done, err_invalid, err_zoom, err_timeout;

    zoom_command_dispatcher_if bus();

    zoom_command_dispatcher #(
        .FIFO_DEPTH (4),
        .ACK_TIMEOUT(4),
        .ZOOM_RESET (3'b010)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .bus        (bus.master),
        .clear_flags(clear_flags),
        .rd_data    (rd_data),
        .busy       (busy),
        .cmd_done   (cmd_done),
        .err_invalid(err_invalid),
        .err_zoom   (err_zoom),
        .err_timeout(err_timeout)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [16:0] addr;
        logic [7:0]  color;
        logic [2:0]  zoom;
    } issue_t;

    // Memory controller model: drops done for mc_delay cycles after each enable.
    bit     mc_ignore = 1'b0;
    bit     mc_hold   = 1'b0;
    int     mc_delay  = 2;
    int     enable_count = 0;
    int     busy_left = 0;
    issue_t issue_log[$];

    initial begin
        issue_t rec;
        bus.mc_done = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.mc_enable) begin
                enable_count++;
                rec.op = bus.mc_operation; rec.addr = bus.mc_addr_base;
                rec.color = bus.mc_color;  rec.zoom = bus.current_zoom;
                issue_log.push_back(rec);
                if (!mc_ignore) begin
                    bus.mc_done = 1'b0;
                    busy_left = mc_delay;
                end
            end else if (busy_left > 0) begin
                busy_left--;
            end else if (!mc_hold) begin
                bus.mc_done = 1'b1;
            end
        end
    end

    // Reference model: zoom as a level 0..4 (0.25x..4x), sticky flags, last read byte.
    int         m_zoom = 2;
    bit         m_inv = 0, m_zm = 0, m_to = 0;
    logic [7:0] m_rd = 8'h00;

    function automatic bit model_step(input logic [31:0] w, input bit ignore, input logic [7:0] rdv);
        int op;
        bit zin, zout;
        op   = int'(w[2:0]);
        zin  = (op == 3) || (op == 4);
        zout = (op == 5) || (op == 6);
        if (op == 7) begin m_inv = 1; return 0; end
        if (op == 0) begin m_zoom = 2; return 0; end
        if ((zin && m_zoom == 4) || (zout && m_zoom == 0)) begin m_zm = 1; return 0; end
        if (ignore) begin m_to = 1; return 1; end
        if (op == 1) m_rd = rdv;
        if (zin)  m_zoom = m_zoom + 1;
        if (zout) m_zoom = m_zoom - 1;
        return 1;
    endfunction

    function automatic issue_t expect_issue(input logic [31:0] w, input int zoom);
        issue_t e;
        e.op = w[2:0]; e.addr = w[19:3]; e.color = w[27:20]; e.zoom = 3'(zoom);
        return e;
    endfunction

    task automatic push_word(input logic [31:0] w, output bit ok);
        ok = 1'b0;
        @(negedge clock);
        bus.instr_in = w;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 300 && !bus.instr_ready; i++) @(negedge clock);
        if (bus.instr_ready) begin
            @(posedge clock);
            ok = 1'b1;
        end
        #1 bus.instr_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clock);
            if (cmd_done) begin cycles = i; break; end
        end
    endtask

    task automatic run_cmd(input logic [31:0] w, output int cycles);
        bit ok;
        push_word(w, ok);
        cycles = -1;
        if (ok) wait_done(cycles);
    endtask

    task automatic test_reset();
        int  cyc, en0;
        bit  ok, seen;
        total++;
        if ({bus.instr_ready, bus.mc_enable, busy, cmd_done, err_invalid, err_zoom, err_timeout} !== 7'b1000000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 1000000",
                {bus.instr_ready, bus.mc_enable, busy, cmd_done, err_invalid, err_zoom, err_timeout});
        end
        total++;
        if ({bus.mc_operation, bus.mc_addr_base, bus.mc_color, rd_data, bus.current_zoom} !== {36'h0, 3'b010}) begin
            bad++; $display("FAIL reset_data: got %h want %h",
                {bus.mc_operation, bus.mc_addr_base, bus.mc_color, rd_data, bus.current_zoom}, {36'h0, 3'b010});
        end
        run_cmd(32'h0000_0004, cyc);
        mc_hold = 1'b1;
        for (int i = 0; i < 4; i++) push_word({$urandom} & 32'hFFFF_FFF8 | 32'h1, ok);
        repeat (6) @(negedge clock);
        total++;
        if (busy !== 1'b1 || bus.current_zoom !== 3'b011) begin
            bad++; $display("FAIL reset_preop: got busy=%b zoom=%b want busy=1 zoom=011", busy, bus.current_zoom);
        end
        reset_n = 1'b0;
        en0 = enable_count;
        #1;
        total++;
        if ({busy, bus.mc_enable, bus.instr_ready, bus.current_zoom} !== 6'b001010) begin
            bad++; $display("FAIL reset_async: got %b want 001010", {busy, bus.mc_enable, bus.instr_ready, bus.current_zoom});
        end
        @(negedge clock);
        reset_n = 1'b1;
        mc_hold = 1'b0;
        m_zoom = 2; m_inv = 0; m_zm = 0; m_to = 0; m_rd = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if ({busy, bus.mc_enable, cmd_done, bus.instr_ready, bus.current_zoom} !== 7'b0001010) seen = 1'b1;
        end
        total++;
        if (seen || enable_count != en0) begin
            bad++; $display("FAIL reset_flush: got disturbed=%0d enables=%0d want disturbed=0 enables=0", seen, enable_count - en0);
        end
        issue_log.delete();
    endtask

    task automatic test_rd();
        bit ok;
        int en_cnt = 0, en_at = -1, done_cnt = 0;
        mc_delay = 3;
        bus.mem_rd_data = 8'hA5;
        void'(model_step(32'h0000_0051, 1'b0, 8'hA5));
        push_word(32'h0000_0051, ok);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (bus.mc_enable) begin en_cnt++; if (en_at < 0) en_at = i; end
            if (cmd_done) done_cnt++;
        end
        total++;
        if (en_cnt != 1 || en_at != 3) begin
            bad++; $display("FAIL rd_enable: got count=%0d at=%0d want count=1 at=3", en_cnt, en_at);
        end
        total++;
        if ({bus.mc_operation, bus.mc_addr_base} !== {3'b001, 17'd10}) begin
            bad++; $display("FAIL rd_bus: got op=%0d addr=%0d want op=1 addr=10", bus.mc_operation, bus.mc_addr_base);
        end
        total++;
        if (rd_data !== m_rd || done_cnt != 1) begin
            bad++; $display("FAIL rd_data: got %h done=%0d want %h done=1", rd_data, done_cnt, m_rd);
        end
        issue_log.delete();
    endtask

    task automatic test_zoom_limit();
        logic [2:0]  ops [8] = '{3'd4, 3'd4, 3'd4, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6};
        logic [31:0] w;
        int cyc, en0;
        bit iss;
        mc_delay = 1;
        for (int k = 0; k < 8; k++) begin
            w = $urandom;
            w[2:0] = ops[k];
            en0 = enable_count;
            iss = model_step(w, 1'b0, bus.mem_rd_data);
            run_cmd(w, cyc);
            total++;
            if ({bus.current_zoom, err_zoom} !== {3'(m_zoom), m_zm} || cyc < 0) begin
                bad++; $display("FAIL zoom_step%0d: got zoom=%b err=%b want zoom=%b err=%b",
                    k, bus.current_zoom, err_zoom, 3'(m_zoom), m_zm);
            end
            total++;
            if (enable_count - en0 != int'(iss)) begin
                bad++; $display("FAIL zoom_enable%0d: got %0d want %0d", k, enable_count - en0, int'(iss));
            end
        end
        issue_log.delete();
    endtask

    task automatic test_fifo_full();
        logic [31:0] w [6];
        bit   [5:0]  acc;
        issue_t      exp_q[$];
        issue_t      got;
        int          cyc, retired;
        mc_hold = 1'b1;
        mc_delay = 2;
        issue_log.delete();
        for (int i = 0; i < 6; i++) begin
            w[i] = {4'h0, 8'($urandom), 17'(i + 100), 3'b010};
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            bus.instr_in = w[i];
            bus.instr_valid = 1'b1;
            acc[i] = bus.instr_ready;
            @(posedge clock);
            #1 bus.instr_valid = 1'b0;
        end
        total++;
        if (acc !== 6'b011111) begin
            bad++; $display("FAIL fifo_ready: got %b want 011111", acc);
        end
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(expect_issue(w[i], m_zoom));
            void'(model_step(w[i], 1'b0, bus.mem_rd_data));
        end
        mc_hold = 1'b0;
        retired = 0;
        for (int i = 0; i < 5; i++) begin
            wait_done(cyc);
            if (cyc > 0) retired++;
        end
        repeat (6) @(negedge clock);
        total++;
        if (retired != 5 || issue_log.size() != 5) begin
            bad++; $display("FAIL fifo_count: got retired=%0d issued=%0d want 5 and 5", retired, issue_log.size());
        end
        while (issue_log.size() > 0 && exp_q.size() > 0) begin
            got = issue_log.pop_front();
            total++;
            if (got !== exp_q[0]) begin
                bad++; $display("FAIL fifo_order: got %h want %h", got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_timeout();
        logic [31:0] w;
        bit ok;
        int cyc = -1;
        mc_ignore = 1'b1;
        w = {$urandom} & 32'hFFFF_FFF8 | 32'h3;
        total++;
        if (err_timeout !== 1'b0) begin
            bad++; $display("FAIL to_pre: got %b want 0", err_timeout);
        end
        void'(model_step(w, 1'b1, bus.mem_rd_data));
        run_cmd(w, cyc);
        total++;
        if (cyc != 8 || err_timeout !== 1'b1 || bus.current_zoom !== 3'(m_zoom)) begin
            bad++; $display("FAIL to_set: got cyc=%0d err=%b zoom=%b want cyc=8 err=1 zoom=%b",
                cyc, err_timeout, bus.current_zoom, 3'(m_zoom));
        end
        @(negedge clock); clear_flags = 1'b1;
        @(negedge clock); clear_flags = 1'b0;
        m_inv = 0; m_zm = 0; m_to = 0;
        total++;
        if ({err_invalid, err_zoom, err_timeout} !== 3'b000) begin
            bad++; $display("FAIL to_clear: got %b want 000", {err_invalid, err_zoom, err_timeout});
        end
        void'(model_step(w, 1'b1, bus.mem_rd_data));
        push_word(w, ok);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (i == 7) begin
                total++;
                if (err_timeout !== 1'b0) begin
                    bad++; $display("FAIL to_early: got %b want 0", err_timeout);
                end
                clear_flags = 1'b1;
            end
            if (i == 8) begin
                clear_flags = 1'b0;
                total++;
                if ({cmd_done, err_timeout} !== 2'b11) begin
                    bad++; $display("FAIL to_set_wins: got %b want 11", {cmd_done, err_timeout});
                end
            end
        end
        mc_ignore = 1'b0;
        issue_log.delete();
    endtask

    task automatic test_invalid_zoomrst();
        int cyc, en0;
        en0 = enable_count;
        void'(model_step(32'h0000_0007, 1'b0, bus.mem_rd_data));
        run_cmd(32'h0000_0007, cyc);
        total++;
        if (cyc != 3 || err_invalid !== 1'b1 || enable_count != en0) begin
            bad++; $display("FAIL invalid: got cyc=%0d err=%b en=%0d want cyc=3 err=1 en=0", cyc, err_invalid, enable_count - en0);
        end
        while (m_zoom < 4) begin
            void'(model_step(32'h0000_0004, 1'b0, bus.mem_rd_data));
            run_cmd(32'h0000_0004, cyc);
        end
        total++;
        if (bus.current_zoom !== 3'b100) begin
            bad++; $display("FAIL zoom_max: got %b want 100", bus.current_zoom);
        end
        en0 = enable_count;
        void'(model_step(32'h0ABC_DEF0, 1'b0, bus.mem_rd_data));
        run_cmd(32'h0ABC_DEF0, cyc);
        total++;
        if (cyc != 3 || bus.current_zoom !== 3'b010 || enable_count != en0) begin
            bad++; $display("FAIL zoom_rst: got cyc=%0d zoom=%b en=%0d want cyc=3 zoom=010 en=0", cyc, bus.current_zoom, enable_count - en0);
        end
        issue_log.delete();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [4];
        issue_t      exp_q[$];
        issue_t      got;
        bit          ok;
        int          cyc;
        mc_delay = $urandom_range(1, 3);
        issue_log.delete();
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            if (i == 0) w[i][2:0] = 3'($urandom_range(1, 2));
            if (model_step(w[i], 1'b0, 8'h00) || 1'b0) exp_q.push_back(expect_issue(w[i], 0));
        end
        // Rebuild expectations with the pre-command zoom level now that the sequence is fixed.
        exp_q.delete();
        m_zoom = int'(bus.current_zoom);
        m_inv = err_invalid; m_zm = err_zoom; m_to = err_timeout;
        for (int i = 0; i < 4; i++) begin
            issue_t e;
            e = expect_issue(w[i], m_zoom);
            if (model_step(w[i], 1'b0, bus.mem_rd_data)) exp_q.push_back(e);
        end
        for (int i = 0; i < 4; i++) push_word(w[i], ok);
        for (int i = 0; i < 4; i++) begin
            wait_done(cyc);
            total++;
            if (cyc < 0 || (i > 0 && cyc < 3)) begin
                bad++; $display("FAIL b2b_gap%0d: got %0d want >=3", i, cyc);
            end
        end
        repeat (3) @(negedge clock);
        total++;
        if (issue_log.size() != exp_q.size() || bus.current_zoom !== 3'(m_zoom)) begin
            bad++; $display("FAIL b2b_count: got issued=%0d zoom=%b want issued=%0d zoom=%b",
                issue_log.size(), bus.current_zoom, exp_q.size(), 3'(m_zoom));
        end
        while (issue_log.size() > 0 && exp_q.size() > 0) begin
            got = issue_log.pop_front();
            total++;
            if (got !== exp_q[0]) begin
                bad++; $display("FAIL b2b_issue: got %h want %h", got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        issue_t      e, got;
        int          cyc, en0;
        bit          iss;
        for (int k = 0; k < 40; k++) begin
            w = $urandom;
            mc_ignore = ($urandom_range(0, 7) == 0);
            mc_delay = $urandom_range(1, 4);
            bus.mem_rd_data = 8'($urandom);
            issue_log.delete();
            en0 = enable_count;
            e = expect_issue(w, m_zoom);
            iss = model_step(w, mc_ignore, bus.mem_rd_data);
            run_cmd(w, cyc);
            mc_ignore = 1'b0;
            total++;
            if (cyc < 0 || {bus.current_zoom, err_invalid, err_zoom, err_timeout} !== {3'(m_zoom), m_inv, m_zm, m_to}) begin
                bad++; $display("FAIL rand_state%0d: got cyc=%0d zoom/flags=%b want %b", k, cyc,
                    {bus.current_zoom, err_invalid, err_zoom, err_timeout}, {3'(m_zoom), m_inv, m_zm, m_to});
            end
            total++;
            if (rd_data !== m_rd || enable_count - en0 != int'(iss)) begin
                bad++; $display("FAIL rand_rd%0d: got rd=%h en=%0d want rd=%h en=%0d", k, rd_data, enable_count - en0, m_rd, int'(iss));
            end
            if (iss && issue_log.size() > 0) begin
                got = issue_log.pop_front();
                total++;
                if (got !== e) begin
                    bad++; $display("FAIL rand_issue%0d: got %h want %h", k, got, e);
                end
            end
            if ($urandom_range(0, 5) == 0) begin
                @(negedge clock); clear_flags = 1'b1;
                @(negedge clock); clear_flags = 1'b0;
                m_inv = 0; m_zm = 0; m_to = 0;
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        clear_flags = 1'b0;
        bus.instr_in = '0;
        bus.instr_valid = 1'b0;
        bus.mem_rd_data = '0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        test_reset();
        test_rd();
        test_zoom_limit();
        test_fifo_full();
        test_timeout();
        test_invalid_zoomrst();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
